// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: HEADER, LEN, payload, CSUM; buffers the payload and
// replays it to a valid/ready consumer once the checksum matches.
module uart_frame_parser #(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 52080
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMO_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ST_HUNT    = 3'd0;
    localparam logic [2:0] ST_LEN     = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CSUM    = 3'd3;
    localparam logic [2:0] ST_OUTPUT  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             rx_low_q;
    logic [7:0]       sum_q, sum_d;
    logic [IDX_W-1:0] len_m1_q, len_m1_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             buf_we;
    logic [7:0]       buf_q [MAX_LEN];

    logic byte_take;
    logic in_frame;
    logic tmo_hit;

    // rx_low_q resets to 0, so a level already high when reset releases is ignored
    assign byte_take = rx_ready && rx_low_q;
    assign in_frame  = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        len_m1_d    = len_m1_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        tmo_d       = '0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        buf_we      = 1'b0;

        if (in_frame && !byte_take) begin
            if (tmo_hit) begin
                frame_err_d = 1'b1;
                state_d     = ST_HUNT;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        case (state_q)
            ST_HUNT: begin
                if (byte_take && rx_data == HEADER) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (byte_take) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT;
                    end else begin
                        len_m1_d = IDX_W'(rx_data - 8'd1);
                        sum_d    = rx_data;
                        wr_idx_d = '0;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (byte_take) begin
                    buf_we   = 1'b1;
                    sum_d    = sum_q + rx_data;
                    wr_idx_d = wr_idx_q + IDX_W'(1);
                    if (wr_idx_q == len_m1_q) state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (byte_take) begin
                    if (rx_data == sum_q) begin
                        rd_idx_d = '0;
                        state_d  = ST_OUTPUT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT;
                    end
                end
            end
            ST_OUTPUT: begin
                if (byte_take) overrun_d = 1'b1;
                if (out_ready) begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                    if (rd_idx_q == len_m1_q) state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            rx_low_q    <= 1'b0;
            sum_q       <= '0;
            len_m1_q    <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_low_q    <= !rx_ready;
            sum_q       <= sum_d;
            len_m1_q    <= len_m1_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_idx_q] <= rx_data;
    end

    assign out_valid = (state_q == ST_OUTPUT);
    assign out_data  = out_valid ? buf_q[rd_idx_q] : '0;
    assign out_last  = out_valid && (rd_idx_q == len_m1_q);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_HUNT);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good/bad frames, length limits,
// backpressure with overrun, timeout and its byte-priority corner, reset mid-frame.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_frame_parser #(
        .HEADER      (8'hAA),
        .MAX_LEN     (16),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vld_cnt = 0;
    int dbl_cnt = 0;
    logic fe_p = 1'b0;
    logic ov_p = 1'b0;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (out_valid) vld_cnt++;
        if ((frame_err && fe_p) || (overrun && ov_p)) dbl_cnt++;
        fe_p = frame_err;
        ov_p = overrun;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (hold) @(negedge clk);
        rx_ready = 1'b0;
    endtask

    // bytes[7:0] is sent first
    task automatic frame(input logic [63:0] bytes, input int n, input int hold);
        for (int i = 0; i < n; i++) send(bytes[8*i +: 8], hold);
    endtask

    task automatic drain(input string tag, input logic [63:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"}, 32'(out_data), 32'(exp[8*i +: 8]));
            chk({tag, "_last"}, 32'(out_last), 32'(i == n - 1));
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    int fe0, ov0, vld0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Good frame, consumer always ready
        fe0 = fe_cnt;
        out_ready = 1'b1;
        frame({8'h69, 8'h33, 8'h22, 8'h11, 8'h03, 8'hAA}, 6, 1);
        drain("good", {8'h33, 8'h22, 8'h11}, 3);
        chk("good_no_ferr", 32'(fe_cnt), 32'(fe0));

        // Bad checksum
        fe0 = fe_cnt;
        vld0 = vld_cnt;
        frame({8'h00, 8'h02, 8'h01, 8'h02, 8'hAA}, 5, 1);
        chk("csum_ferr", 32'(frame_err), 32'd1);
        chk("csum_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("csum_ferr_end", 32'(frame_err), 32'd0);
        chk("csum_busy", 32'(busy), 32'd0);
        chk("csum_ferr_cnt", 32'(fe_cnt), 32'(fe0 + 1));
        chk("csum_no_valid", 32'(vld_cnt), 32'(vld0));

        // Length zero and length above MAX_LEN, then a 1-byte frame
        frame({8'h00, 8'hAA}, 2, 1);
        chk("len0_ferr", 32'(frame_err), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        frame({8'h11, 8'hAA}, 2, 1);
        chk("len17_ferr", 32'(frame_err), 32'd1);
        chk("len17_busy", 32'(busy), 32'd0);
        frame({8'h5B, 8'h5A, 8'h01, 8'hAA}, 4, 1);
        drain("len1", {8'h5A}, 1);

        // Backpressure with a byte arriving during OUTPUT
        ov0 = ov_cnt;
        out_ready = 1'b0;
        frame({8'h63, 8'h30, 8'h20, 8'h10, 8'h03, 8'hAA}, 6, 1);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_data", 32'(out_data), 32'h10);
        send(8'h44, 1);
        chk("bp_overrun", 32'(overrun), 32'd1);
        chk("bp_data_hold", 32'(out_data), 32'h10);
        repeat (17) @(negedge clk);
        chk("bp_data_hold2", 32'(out_data), 32'h10);
        chk("bp_ovr_cnt", 32'(ov_cnt), 32'(ov0 + 1));
        drain("bp", {8'h30, 8'h20, 8'h10}, 3);

        // Byte arrives on the very cycle the timeout would fire
        fe0 = fe_cnt;
        out_ready = 1'b1;
        frame({8'h02, 8'hAA}, 2, 1);
        repeat (98) @(negedge clk);
        send(8'h07, 1);
        chk("prio_ferr", 32'(frame_err), 32'd0);
        chk("prio_busy", 32'(busy), 32'd1);
        frame({8'h11, 8'h08}, 2, 1);
        drain("prio", {8'h08, 8'h07}, 2);
        chk("prio_ferr_cnt", 32'(fe_cnt), 32'(fe0));

        // Timeout mid-payload
        frame({8'h01, 8'h04, 8'hAA}, 3, 1);
        repeat (99) @(negedge clk);
        chk("tmo_before", 32'(frame_err), 32'd0);
        chk("tmo_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        chk("tmo_ferr", 32'(frame_err), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        frame({8'h5B, 8'h5A, 8'h01, 8'hAA}, 4, 1);
        drain("tmo_next", {8'h5A}, 1);

        // rx_ready held three cycles per byte
        fe0 = fe_cnt;
        frame({8'h63, 8'h30, 8'h20, 8'h10, 8'h03, 8'hAA}, 6, 3);
        drain("hold3", {8'h30, 8'h20, 8'h10}, 3);

        // Reset in the middle of PAYLOAD, released with rx_ready already high
        frame({8'h01, 8'h03, 8'hAA}, 3, 3);
        chk("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rx_data  = 8'hAA;
        rx_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("inrst_valid", 32'(out_valid), 32'd0);
        chk("inrst_data", 32'(out_data), 32'd0);
        chk("inrst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        rx_ready = 1'b0;
        frame({8'h5B, 8'h5A, 8'h01, 8'hAA}, 4, 3);
        drain("post_rst", {8'h5A}, 1);
        chk("rst_no_ferr", 32'(fe_cnt), 32'(fe0));
        chk("pulse_width", 32'(dbl_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
